// File: rtl/gpio_pad_filter_pkg.sv
// Shared GPIO constants and types.
// Imported by the pad filter and the GPIO block.
package gpio_pkg;

   localparam int GPIO_WIDTH       = 8;
   localparam int GPIO_SYNC_STAGES = 2;
   localparam int GPIO_DEBOUNCE_W  = 16;

   localparam logic GPIO_DIR_IN  = 1'b0;
   localparam logic GPIO_DIR_OUT = 1'b1;

   typedef struct packed {
      logic rise;
      logic fall;
   } gpio_edge_t;

   // Edge events are only reported for pads the GPIO is not driving.
   function automatic logic gpio_is_input(logic dir);
      return dir != GPIO_DIR_OUT;
   endfunction

endpackage

// File: rtl/gpio_pad_filter_if.sv
// Signal bundle between the pad side/register side and the filter.
// master drives pads and controls, slave presents filtered results.
interface gpio_pad_filter_if #(
   parameter int WIDTH      = 8,
   parameter int DEBOUNCE_W = 16
);

   logic [WIDTH-1:0]      pad;
   logic [WIDTH-1:0]      dir;
   logic [DEBOUNCE_W-1:0] limit;
   logic [WIDTH-1:0]      rise_en;
   logic [WIDTH-1:0]      fall_en;
   logic [WIDTH-1:0]      clr;
   logic [WIDTH-1:0]      port;
   logic [WIDTH-1:0]      rise;
   logic [WIDTH-1:0]      fall;
   logic [WIDTH-1:0]      pend;
   logic                  irq;

   modport master (
      output pad, dir, limit,
      output rise_en, fall_en, clr,
      input  port, rise, fall, pend, irq
   );

   modport slave (
      input  pad, dir, limit,
      input  rise_en, fall_en, clr,
      output port, rise, fall, pend, irq
   );

endinterface

// File: rtl/gpio_debounce_bit.sv
// One pad bit: synchroniser, debounce counter, stable level and
// registered edge pulses.
module gpio_debounce_bit
   import gpio_pkg::*;
#(
   parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
   parameter int DEBOUNCE_W  = GPIO_DEBOUNCE_W
) (
   input  logic                  HCLK_I,
   input  logic                  HRESET_I,
   input  logic                  pad,
   input  logic                  dir,
   input  logic [DEBOUNCE_W-1:0] limit,
   output logic                  level,
   output logic                  rise,
   output logic                  fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DEBOUNCE_W-1:0]  cnt;
   logic                   st;
   logic                   s;
   logic                   differ;
   logic                   expire;
   logic                   take;
   gpio_edge_t             evt;

   assign s     = sync_q[SYNC_STAGES-1];
   assign level = st;

   // Shift the raw pad level through the synchroniser chain.
   always_ff @(posedge HCLK_I or posedge HRESET_I) begin
      if (HRESET_I) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pad};
      end
   end

   // Decide whether the synchronised level is accepted this edge.
   always_comb begin
      differ   = s ^ st;
      expire   = cnt >= limit;
      take     = differ & expire;
      evt.rise = take & s & gpio_is_input(dir);
      evt.fall = take & ~s & gpio_is_input(dir);
   end

   // Count how long s has disagreed with st, then adopt it.
   always_ff @(posedge HCLK_I or posedge HRESET_I) begin
      if (HRESET_I) begin
         cnt  <= '0;
         st   <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         rise <= evt.rise;
         fall <= evt.fall;
         if (!differ) begin
            cnt <= '0;
         end else if (expire) begin
            st  <= s;
            cnt <= '0;
         end else begin
            cnt <= cnt + DEBOUNCE_W'(1);
         end
      end
   end

endmodule

// File: rtl/gpio_pad_filter.sv
// GPIO pad conditioning: per-bit sync and debounce, edge events,
// sticky interrupt pending flags with write-one-to-clear.
module gpio_pad_filter
   import gpio_pkg::*;
#(
   parameter int WIDTH       = GPIO_WIDTH,
   parameter int SYNC_STAGES = GPIO_SYNC_STAGES,
   parameter int DEBOUNCE_W  = GPIO_DEBOUNCE_W
) (
   input  logic                  HCLK_I,
   input  logic                  HRESET_I,
   input  logic [WIDTH-1:0]      PAD_I,
   input  logic [WIDTH-1:0]      DIR_I,
   input  logic [DEBOUNCE_W-1:0] DEBOUNCE_LIMIT_I,
   input  logic [WIDTH-1:0]      IRQ_RISE_EN_I,
   input  logic [WIDTH-1:0]      IRQ_FALL_EN_I,
   input  logic [WIDTH-1:0]      IRQ_CLR_I,
   output logic [WIDTH-1:0]      PORT_O,
   output logic [WIDTH-1:0]      RISE_O,
   output logic [WIDTH-1:0]      FALL_O,
   output logic [WIDTH-1:0]      PEND_O,
   output logic                  IRQ_O
);

   logic [WIDTH-1:0] pend_set;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      gpio_debounce_bit #(
         .SYNC_STAGES (SYNC_STAGES),
         .DEBOUNCE_W  (DEBOUNCE_W)
      ) u_bit (
         .HCLK_I   (HCLK_I),
         .HRESET_I (HRESET_I),
         .pad      (PAD_I[i]),
         .dir      (DIR_I[i]),
         .limit    (DEBOUNCE_LIMIT_I),
         .level    (PORT_O[i]),
         .rise     (RISE_O[i]),
         .fall     (FALL_O[i])
      );
   end

   // Enabled edge events that raise a pending flag.
   always_comb begin
      pend_set = (RISE_O & IRQ_RISE_EN_I)
               | (FALL_O & IRQ_FALL_EN_I);
   end

   // Sticky pending flags; a new event wins over a same-cycle clear.
   always_ff @(posedge HCLK_I or posedge HRESET_I) begin
      if (HRESET_I) begin
         PEND_O <= '0;
      end else begin
         PEND_O <= (PEND_O & ~IRQ_CLR_I) | pend_set;
      end
   end

   assign IRQ_O = |PEND_O;

endmodule

// File: tb/tb_gpio_pad_filter.sv
// Scoreboard bench for gpio_pad_filter: window-based reference
// model feeds an expectation queue, a monitor compares every cycle.
module tb_gpio_pad_filter;
   import gpio_pkg::*;

   localparam int W  = 8;
   localparam int DW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   gpio_pad_filter_if #(.WIDTH(W), .DEBOUNCE_W(DW)) bus ();

   gpio_pad_filter #(
      .WIDTH       (W),
      .SYNC_STAGES (2),
      .DEBOUNCE_W  (DW)
   ) dut (
      .HCLK_I           (clk),
      .HRESET_I         (rst),
      .PAD_I            (bus.pad),
      .DIR_I            (bus.dir),
      .DEBOUNCE_LIMIT_I (bus.limit),
      .IRQ_RISE_EN_I    (bus.rise_en),
      .IRQ_FALL_EN_I    (bus.fall_en),
      .IRQ_CLR_I        (bus.clr),
      .PORT_O           (bus.port),
      .RISE_O           (bus.rise),
      .FALL_O           (bus.fall),
      .PEND_O           (bus.pend),
      .IRQ_O            (bus.irq)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   // Reference model: s at edge k is the pad seen at edge k-2; the
   // stable level flips when the last L+1 values of s all differ.
   logic [W-1:0]  pq[$];
   logic [W-1:0]  sh[$];
   logic [32:0]   exp_q[$];
   logic [W-1:0]  m_st, m_rise, m_fall, m_pend;

   initial begin
      m_st = '0; m_rise = '0; m_fall = '0; m_pend = '0;
   end

   always @(posedge clk) begin
      logic [W-1:0] s_k, tmp, flip, npend, nr, nf;
      int k, lim, idx;
      if (rst) begin
         pq.delete(); sh.delete();
         m_st = '0; m_rise = '0; m_fall = '0; m_pend = '0;
      end else begin
         k   = sh.size();
         s_k = (k >= 2) ? pq[k-2] : '0;
         sh.push_back(s_k);
         lim = int'(bus.limit);
         for (int i = 0; i < W; i++) begin
            flip[i] = 1'b1;
            for (int j = 0; j <= lim; j++) begin
               idx = k - j;
               tmp = (idx >= 0) ? sh[idx] : '0;
               if (tmp[i] == m_st[i]) flip[i] = 1'b0;
            end
         end
         npend = (m_pend & ~bus.clr) | (m_rise & bus.rise_en)
               | (m_fall & bus.fall_en);
         nr = flip & s_k & ~bus.dir;
         nf = flip & ~s_k & ~bus.dir;
         m_st   = (m_st & ~flip) | (s_k & flip);
         m_rise = nr;
         m_fall = nf;
         m_pend = npend;
         pq.push_back(bus.pad);
      end
      exp_q.push_back({m_st, m_rise, m_fall, m_pend, |m_pend});
   end

   // Monitor: compare DUT outputs against the oldest expectation.
   initial begin
      logic [32:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            chk("sb_empty", 64'd0, 64'd1);
         end else begin
            e = exp_q.pop_front();
            chk("sb_cycle",
                {31'd0, bus.port, bus.rise, bus.fall, bus.pend, bus.irq},
                {31'd0, e});
         end
      end
   end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_zero(string name);
      #1;
      chk(name, {bus.port, bus.rise, bus.fall, bus.pend,
                 7'd0, bus.irq}, 64'd0);
   endtask

   initial begin
      logic [W-1:0] m;
      bus.pad = 8'hFF; bus.dir = '0; bus.limit = '0;
      bus.rise_en = '0; bus.fall_en = '0; bus.clr = '0;

      // Reset with high pads, L = 0
      tick(3);
      chk_zero("reset_outputs");
      rst = 1'b0;
      tick(2);
      chk("l0_port_edge1", bus.port, 8'h00);
      tick(1);
      chk("l0_port_edge2", bus.port, 8'hFF);
      chk("l0_rise", bus.rise, 8'hFF);
      tick(1);
      chk("l0_rise_once", bus.rise, 8'h00);
      bus.pad = 8'h00;
      tick(6);

      // Glitch rejection at L = 4
      bus.limit = 16'd4;
      bus.pad[0] = 1'b1;
      tick(4);
      bus.pad[0] = 1'b0;
      tick(10);
      chk("glitch_port0", bus.port[0], 1'b0);
      bus.pad[0] = 1'b1;
      tick(6);
      chk("l4_port0_early", bus.port[0], 1'b0);
      tick(1);
      chk("l4_port0_edge6", bus.port[0], 1'b1);
      chk("l4_rise0", bus.rise[0], 1'b1);
      tick(1);
      chk("l4_rise0_once", bus.rise[0], 1'b0);

      // Falling-edge interrupt on bit 2
      bus.limit = '0;
      bus.fall_en = 8'h04;
      bus.pad[2] = 1'b1;
      tick(5);
      chk("rise_no_pend", bus.pend, 8'h00);
      bus.pad[2] = 1'b0;
      tick(3);
      chk("fall2", bus.fall[2], 1'b1);
      tick(1);
      chk("pend2", bus.pend, 8'h04);
      chk("irq2", bus.irq, 1'b1);
      bus.clr = 8'h04;
      tick(1);
      bus.clr = '0;
      chk("clr2", bus.pend, 8'h00);
      bus.fall_en = '0;

      // Set beats clear on bit 1
      bus.rise_en = 8'h02;
      bus.pad[1] = 1'b1;
      tick(3);
      chk("rise1", bus.rise[1], 1'b1);
      tick(1);
      chk("pend1", bus.pend[1], 1'b1);
      bus.pad[1] = 1'b0;
      tick(5);
      bus.pad[1] = 1'b1;
      tick(3);
      chk("rise1_again", bus.rise[1], 1'b1);
      bus.clr = 8'h02;
      tick(1);
      bus.clr = '0;
      chk("set_beats_clr", bus.pend[1], 1'b1);
      bus.clr = 8'h02;
      tick(1);
      bus.clr = '0;
      chk("clr1", bus.pend, 8'h00);
      bus.rise_en = '0;

      // Output-direction masking on bit 7
      bus.dir = 8'h80;
      bus.rise_en = 8'hFF;
      bus.fall_en = 8'hFF;
      bus.pad[7] = 1'b1;
      tick(3);
      chk("out_port7_hi", bus.port[7], 1'b1);
      chk("out_rise7", bus.rise[7], 1'b0);
      tick(1);
      chk("out_pend7_a", bus.pend[7], 1'b0);
      bus.pad[7] = 1'b0;
      tick(3);
      chk("out_port7_lo", bus.port[7], 1'b0);
      chk("out_fall7", bus.fall[7], 1'b0);
      tick(1);
      chk("out_pend7_b", bus.pend[7], 1'b0);
      bus.dir = '0;
      bus.rise_en = '0;
      bus.fall_en = '0;
      bus.clr = 8'hFF;
      tick(1);
      bus.clr = '0;

      // Lowering L mid-count on bit 3
      bus.limit = 16'd100;
      bus.pad[3] = 1'b1;
      tick(52);
      chk("l100_hold", bus.port[3], 1'b0);
      bus.limit = 16'd10;
      tick(1);
      chk("limit_drop", bus.port[3], 1'b1);
      bus.limit = '0;
      bus.pad[3] = 1'b0;
      tick(5);

      // Reset mid-count on bit 3
      bus.limit = 16'd100;
      bus.pad[3] = 1'b1;
      tick(30);
      rst = 1'b1;
      chk_zero("midcount_reset");
      tick(3);
      bus.limit = '0;
      rst = 1'b0;
      tick(2);
      chk("restart_edge1", bus.port[3], 1'b0);
      tick(1);
      chk("restart_edge2", bus.port[3], 1'b1);

      // Randomised traffic
      for (int c = 0; c < 1500; c++) begin
         m = '0;
         for (int i = 0; i < W; i++)
            if ($urandom_range(0, 5) == 0) m[i] = 1'b1;
         bus.pad = bus.pad ^ m;
         if ($urandom_range(0, 40) == 0)
            bus.limit = DW'($urandom_range(0, 6));
         if ($urandom_range(0, 60) == 0) bus.dir = W'($urandom);
         if ($urandom_range(0, 30) == 0) begin
            bus.rise_en = W'($urandom);
            bus.fall_en = W'($urandom);
         end
         bus.clr = ($urandom_range(0, 7) == 0) ? W'($urandom) : '0;
         tick(1);
      end
      bus.clr = '0;
      tick(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/gpio_pad_filter.md
# gpio_pad_filter

Input conditioning stage between the GPIO pads and the `ahb_gpio` `PORT_I` input. It synchronises each pad bit into `HCLK_I` and debounces it per bit with a programmable limit. It detects rising and falling edges on the debounced value and keeps per-bit interrupt pending flags, which are cleared by write-one-to-clear. Pads whose direction bit is output still filter, but generate no edge events or pending flags.

## Interface
Parameters:
- `WIDTH`, 8, number of GPIO bits.
- `SYNC_STAGES`, 2, synchroniser depth (≥2).
- `DEBOUNCE_W`, 16, debounce counter and limit width.

Ports:
- `HCLK_I` in 1: the single clock.
- `HRESET_I` in 1: reset, asynchronous, active-high.
- `PAD_I` in WIDTH: raw asynchronous pad levels.
- `DIR_I` in WIDTH: per-bit direction from the GPIO block (`DIR_O`); 1 = output.
- `DEBOUNCE_LIMIT_I` in DEBOUNCE_W: quasi-static debounce limit L.
- `IRQ_RISE_EN_I` in WIDTH: per-bit rising-edge interrupt enable.
- `IRQ_FALL_EN_I` in WIDTH: per-bit falling-edge interrupt enable.
- `IRQ_CLR_I` in WIDTH: per-bit clear strobe, one cycle, write-one-to-clear.
- `PORT_O` out WIDTH: debounced level; feeds the GPIO `PORT_I`.
- `RISE_O` out WIDTH: one-cycle pulse on a debounced 0→1 transition.
- `FALL_O` out WIDTH: one-cycle pulse on a debounced 1→0 transition.
- `PEND_O` out WIDTH: interrupt pending flags.
- `IRQ_O` out 1: OR of `PEND_O`.

## Operation
- **Reset:** All flops clear asynchronously on `HRESET_I`: synchroniser stages, counters, `PORT_O`, `RISE_O`, `FALL_O`, `PEND_O`, `IRQ_O`. All outputs read 0 while reset is asserted.
- **Synchroniser:** Each bit passes through a SYNC_STAGES flop chain. The last stage is the signal `s`.
- **Debounce, per bit:** one counter `cnt` and one stable register `st` (which drives `PORT_O`). On each clock edge:
  - If `s == st`: `cnt <= 0`.
  - Else if `cnt >= L`: `st <= s`, `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - The `>=` comparison means lowering L mid-count takes effect immediately, with no overshoot. The counter never exceeds L, so it never wraps.
  - L = 0 means no debounce: `st` follows `s` one edge later.
  - A glitch on `s` shorter than L+1 consecutive cycles never reaches `PORT_O`.
- **Edges:**
  - `RISE_O[i]` and `FALL_O[i]` are registered. They assert in the same cycle `PORT_O[i]` first shows the new value, for exactly one cycle.
  - Both are forced to 0 when `DIR_I[i] = 1`.
- **Pending, per bit:**
  - Set on `(RISE & IRQ_RISE_EN) | (FALL & IRQ_FALL_EN)`.
  - Cleared by `IRQ_CLR_I`.
  - If set and clear occur in the same cycle, set wins.
  - A bit that is already pending stays pending; events are not counted.
  - Changing `DIR_I` or the enables does not clear pending bits.
- **`IRQ_O`:** OR of the `PEND_O` flops. It is combinational from flops only.
- **Reset release with a high pad:** the bit debounces from `st = 0` and produces a `RISE_O` pulse. Software clears it.

## Timing
- **Pad-to-`PORT_O` latency:** `PORT_O` updates on the (SYNC_STAGES + L)-th clock edge after the first edge that samples the new pad level, counting that sampling edge as edge 0. The pad must stay constant during that window. With the defaults and L = 0, `PORT_O` changes after edge 2.
- **Event-to-flag latency:** `PEND_O` and `IRQ_O` rise one cycle after the `RISE_O`/`FALL_O` pulse.
- **Clear latency:** `PEND_O` drops one cycle after the `IRQ_CLR_I` cycle.
- **`DEBOUNCE_LIMIT_I`:** may change at any time, with no glitch on outputs. The new value applies from the next edge.
- **Reset mid-count:** counter contents are discarded. After release, filtering restarts from `st = 0`.

## Structure
- **Package `gpio_pkg`:**
  - `GPIO_WIDTH` = 8.
  - `GPIO_SYNC_STAGES` = 2.
  - `GPIO_DEBOUNCE_W` = 16.
  - Direction encoding constants `GPIO_DIR_IN` = 0 and `GPIO_DIR_OUT` = 1, shared with `ahb_gpio`.
- **Sub-module `gpio_debounce_bit`:**
  - Contains one synchroniser chain, the counter and `st`, plus rise/fall generation.
  - Instantiated WIDTH times in a generate loop.
  - Pending logic and the `IRQ_O` OR stay in the top level.

## Test plan
- **Reset and L = 0:** Assert reset with `PAD_I = 8'hFF`, `DIR_I = 0`, L = 0, enables 0, then release. Required: all outputs 0 during reset. After release, `PORT_O = 8'hFF` after edge 2 and `RISE_O = 8'hFF` for exactly one cycle.
- **Glitch rejection and limit boundary:** L = 4.
  - Drive `PAD_I[0]` high for 4 cycles, then low. Required: `PORT_O[0]` stays 0.
  - Drive it high for 5 or more cycles. Required: `PORT_O[0]` = 1 at edge SYNC_STAGES + 4, and `RISE_O[0]` pulses once.
- **Interrupt flow:** `IRQ_FALL_EN_I = 8'h04`, then a debounced 1→0 on bit 2. Required: `PEND_O = 8'h04` and `IRQ_O = 1` one cycle after `FALL_O[2]`. A debounced rise on bit 2 sets nothing. `IRQ_CLR_I = 8'h04` gives `PEND_O = 0` on the next cycle.
- **Set beats clear:** With `PEND_O[1] = 1`, assert `IRQ_CLR_I[1]` in the same cycle as a new enabled `RISE_O[1]`. Required: `PEND_O[1]` stays 1.
- **Output masking:** Set `DIR_I = 8'h80` and toggle `PAD_I[7]`. Required: `PORT_O[7]` follows, with `RISE_O[7]`, `FALL_O[7]` and `PEND_O[7]` all 0.
- **Mid-count limit drop and reset:** With L = 100, drive `PAD_I[3]` high and wait until the counter reaches 50.
  - Set L = 10. Required: `PORT_O[3] = 1` on the next edge.
  - Repeat, but assert reset mid-count. Required: all outputs 0 immediately, and filtering restarts after release.
